// File: rtl/slow_tick_bcd_counter.sv
// slow_tick_bcd_counter: four-digit up/down BCD counter stepped by sampled slow_clock edges, with multiplexed 7-segment drive.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module slow_tick_bcd_counter #(
  parameter int REFRESH_BITS = 16
) (
  input  logic        input_clock,
  input  logic        reset,
  input  logic        slow_clock,
  input  logic        enable,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] bcd,
  output logic        tick,
  output logic        rollover,
  output logic [3:0]  an,
  output logic [6:0]  seg
);
  logic                    slow_q;
  logic                    rise;
  logic [REFRESH_BITS-1:0] scan;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    blank;
  logic [15:0]             stepped;
  logic [15:0]             loaded;
  logic                    carry;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      default: seg_of = 7'b0010000;
    endcase
  endfunction

  assign rise  = slow_clock & ~slow_q;
  assign sel   = scan[REFRESH_BITS-1 -: 2];
  assign digit = bcd[4*sel +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = (sel == 2'd3) ? ~|bcd[15:12] :
                 (sel == 2'd2) ? ~|bcd[15:8]  :
                 (sel == 2'd1) ? ~|bcd[15:4]  : 1'b0;
`else
  assign blank = 1'b0;
`endif

  // carry/borrow ripples digit by digit; final carry means the whole count wrapped
  always_comb begin
    stepped = bcd;
    loaded  = '0;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry)
        stepped[4*i +: 4] = up_down ? ((bcd[4*i +: 4] == 4'd9) ? 4'd0 : bcd[4*i +: 4] + 4'd1)
                                    : ((bcd[4*i +: 4] == 4'd0) ? 4'd9 : bcd[4*i +: 4] - 4'd1);
      carry = carry & (bcd[4*i +: 4] == (up_down ? 4'd9 : 4'd0));
      loaded[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
    end
  end

  always_ff @(posedge input_clock) begin
    if (reset) begin
      slow_q   <= 1'b1;
      tick     <= 1'b0;
      rollover <= 1'b0;
      bcd      <= '0;
      scan     <= '0;
      an       <= 4'b1110;
      seg      <= 7'b1000000;
    end else begin
      slow_q   <= slow_clock;
      tick     <= rise;
      rollover <= rise & enable & ~load & carry;
      bcd      <= load ? loaded : (rise & enable) ? stepped : bcd;
      scan     <= scan + 1'b1;
      an       <= ~(4'b0001 << sel);
      seg      <= blank ? 7'b1111111 : seg_of(digit);
    end
  end
endmodule
